// File: rtl/fetch_queue.sv
// fetch_queue: a FIFO that sits between the fetch (PC) stage and decode.
// It holds up to DEPTH {pc, instr} pairs, and the head entry is visible on
// out_* in the same cycle it reaches the head (first-word-fall-through).
// When the queue is full it raises fetch_pause to hold the PC stage.
// A flush (branch or jump redirect) drops every buffered entry.
// When the queue is empty, decode sees a NOP and the PC 32'hFFFFFFFC.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  output logic                       fetch_pause,
  input  logic                       flush,
  input  logic                       id_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // fetch_pause depends only on registered occupancy, so it has no combinational path from id_ready.
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign fetch_pause = full;
  assign count       = count_q;

  // A flush blocks both push and pop. A push offered while full is refused, even if a pop happens in that cycle.
  assign push = in_valid & ~full & ~flush;
  assign pop  = ~empty & id_ready & ~flush;

  // Write storage. It is not reset, because count_q decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_pc, in_instr};
    end
  end

  // Update the pointers and occupancy. A flush clears everything back to the empty state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Present the head entry, or a NOP with the sentinel PC when the queue is empty.
  always_comb begin
    out_valid = 1'b0;
    out_pc    = 32'hFFFFFFFC;
    out_instr = NOP_INSN;
    if (!empty) begin
      out_valid = 1'b1;
      out_pc    = mem[rd_ptr][63:32];
      out_instr = mem[rd_ptr][31:0];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios followed by randomized traffic. All
// checks compare against a queue-based reference model of the FIFO.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] EMPTY_PC = 32'hFFFFFFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        fetch_pause;
  logic        flush = 1'b0;
  logic        id_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int total = 0;
  int bad = 0;

  logic [63:0] model_q[$];

  fetch_queue #(.DEPTH(DEPTH), .NOP_INSN(NOP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .fetch_pause(fetch_pause), .flush(flush), .id_ready(id_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue, updated with the same acceptance rules as the FIFO.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      automatic bit do_push = in_valid && (model_q.size() < DEPTH);
      automatic bit do_pop  = id_ready && (model_q.size() != 0);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back({in_pc, in_instr});
    end
  end

  // Compare every output against the model once per cycle, away from the active clock edge.
  always @(negedge clk) begin
    if (rst) begin
      automatic int n = model_q.size();
      chk("m_count", 32'(count), 32'(n));
      chk("m_valid", 32'(out_valid), 32'(n != 0));
      chk("m_pause", 32'(fetch_pause), 32'(n == DEPTH));
      chk("m_pc", out_pc, (n != 0) ? model_q[0][63:32] : EMPTY_PC);
      chk("m_instr", out_instr, (n != 0) ? model_q[0][31:0] : NOP);
    end
  end

  // Apply one set of inputs and return at the following negedge.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    in_valid = v; in_pc = pc; in_instr = ins; id_ready = rdy; flush = fl;
    @(negedge clk);
  endtask

  initial begin
    // 1: reset
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_instr", out_instr, 32'h00000013);
    chk("rst_pc", out_pc, 32'hFFFFFFFC);
    chk("rst_pause", 32'(fetch_pause), 0);

    // 2: fill the queue, then offer one more push that must be refused
    for (int i = 0; i < 4; i++) drive(1, 32'(4 * i), 32'hA0 + 32'(i), 0, 0);
    chk("fill_count", 32'(count), 4);
    chk("fill_pause", 32'(fetch_pause), 1);
    drive(1, 32'd16, 32'hA4, 0, 0);
    chk("full_count", 32'(count), 4);
    chk("full_head_pc", out_pc, 0);
    chk("full_head_instr", out_instr, 32'hA0);

    // 3: drain and check the output order
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", out_pc, 32'(4 * i));
      drive(0, 0, 0, 1, 0);
      chk("drain_count", 32'(count), 32'(3 - i));
      if (i == 0) chk("drain_pause", 32'(fetch_pause), 0);
    end
    chk("drain_empty_instr", out_instr, NOP);

    // 4: push and pop together with the occupancy held at 2
    drive(1, 32'h100, 32'hB0, 0, 0);
    drive(1, 32'h104, 32'hB1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("flow_trail", out_pc, 32'h108 + 32'(4 * i) - 32'd8);
      drive(1, 32'h108 + 32'(4 * i), 32'hB2 + 32'(i), 1, 0);
      chk("flow_count", 32'(count), 2);
    end

    // 5: flush at count 3 with a push and a pop both offered
    drive(1, 32'h200, 32'hC0, 0, 0);
    chk("pre_flush_count", 32'(count), 3);
    drive(1, 32'h40, 32'hC1, 1, 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_instr", out_instr, NOP);
    chk("flush_pc", out_pc, EMPTY_PC);
    drive(0, 0, 0, 0, 0);
    chk("flush_no_ghost", 32'(out_valid), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(3, 0) != 0, $urandom, $urandom,
            $urandom_range(1, 0) == 1, $urandom_range(15, 0) == 0);
    end

    // 6: assert reset asynchronously between clock edges with count 3
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 32'h300 + 32'(4 * i), 32'hD0 + 32'(i), 0, 0);
    in_valid = 0;
    chk("pre_arst_count", 32'(count), 3);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_pc", out_pc, EMPTY_PC);
    chk("arst_instr", out_instr, NOP);
    chk("arst_pause", 32'(fetch_pause), 0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 1, 0);
    chk("post_arst_count", 32'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
